// File: rtl/el2_mubi_pkg.sv
// el2_mubi_pkg: multi-bit boolean type and its two valid encodings
package el2_mubi_pkg;
    typedef logic [3:0] el2_mubi_t;
    localparam el2_mubi_t El2MubiTrue  = 4'h6;
    localparam el2_mubi_t El2MubiFalse = 4'h9;
endpackage

// File: rtl/el2_pkg.sv
// el2_pkg: shared types for the lockstep control logic
package el2_pkg;
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INJECT   = 3'd1,
        ST_WAIT_DET = 3'd2,
        ST_SH_RST   = 3'd3,
        ST_RECOVER  = 3'd4,
        ST_DONE     = 3'd5
    } el2_lockstep_st_e;
endpackage

// File: rtl/el2_lockstep_selftest_fsm.sv
// el2_lockstep_selftest_fsm: injects an error, waits for detection, resets the shadow core and reports pass/fail
//   clk, rst          : clock, async active-high reset
//   det_i             : checker currently flags corruption
//   start_i           : self-test start strobe (honoured only in IDLE)
//   inj_en_o          : error-injection enable to the shadow core
//   shadow_rst_req_o  : shadow core reset request
//   busy_o / busy_nxt_o : registered busy flag and the value it takes next cycle
//   done_o, pass_o    : completion pulse and held result
module el2_lockstep_selftest_fsm
    import el2_mubi_pkg::*;
    import el2_pkg::*;
#(
    parameter int DET_TIMEOUT       = 64,
    parameter int SHADOW_RST_CYCLES = 4,
    parameter int RECOVER_TIMEOUT   = 64
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      det_i,
    input  logic      start_i,
    output el2_mubi_t inj_en_o,
    output logic      shadow_rst_req_o,
    output logic      busy_o,
    output logic      busy_nxt_o,
    output logic      done_o,
    output logic      pass_o
);
    localparam int TMAX = (DET_TIMEOUT > RECOVER_TIMEOUT)
                        ? ((DET_TIMEOUT > SHADOW_RST_CYCLES) ? DET_TIMEOUT : SHADOW_RST_CYCLES)
                        : ((RECOVER_TIMEOUT > SHADOW_RST_CYCLES) ? RECOVER_TIMEOUT : SHADOW_RST_CYCLES);
    localparam int TW = $clog2(TMAX) + 1;
    el2_lockstep_st_e state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic pass_q, pass_d;
    el2_mubi_t inj_q;
    logic shrst_q, busy_q, done_q;
    // Timer clears by default so every state entry starts from zero; it only
    // advances while below its limit, so it can never wrap.
    always_comb begin
        state_d = state_q;
        tmr_d   = '0;
        pass_d  = pass_q;
        unique case (state_q)
            ST_IDLE: if (start_i) begin
                state_d = ST_INJECT;
                pass_d  = 1'b0;
            end
            ST_INJECT: state_d = ST_WAIT_DET;
            ST_WAIT_DET:
                if (det_i) state_d = ST_SH_RST;
                else if (tmr_q == TW'(DET_TIMEOUT - 1)) begin
                    state_d = ST_DONE;
                    pass_d  = 1'b0;
                end else tmr_d = tmr_q + TW'(1);
            ST_SH_RST:
                if (tmr_q == TW'(SHADOW_RST_CYCLES - 1)) state_d = ST_RECOVER;
                else tmr_d = tmr_q + TW'(1);
            ST_RECOVER:
                if (!det_i) begin
                    state_d = ST_DONE;
                    pass_d  = 1'b1;
                end else if (tmr_q == TW'(RECOVER_TIMEOUT - 1)) begin
                    state_d = ST_DONE;
                    pass_d  = 1'b0;
                end else tmr_d = tmr_q + TW'(1);
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end
    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            pass_q  <= 1'b0;
            inj_q   <= El2MubiFalse;
            shrst_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            pass_q  <= pass_d;
            inj_q   <= (state_d == ST_INJECT || state_d == ST_WAIT_DET) ? El2MubiTrue : El2MubiFalse;
            shrst_q <= state_d == ST_SH_RST;
            busy_q  <= state_d != ST_IDLE;
            done_q  <= state_d == ST_DONE;
        end
    end
    assign inj_en_o         = inj_q;
    assign shadow_rst_req_o = shrst_q;
    assign busy_o           = busy_q;
    assign busy_nxt_o       = state_d != ST_IDLE;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
endmodule

// File: rtl/el2_lockstep_alarm_ctrl.sv
// el2_lockstep_alarm_ctrl: alarm latching/counting, NMI and detection-disable control around the lockstep checker
//   corruption_detected_i : checker flag, anything but El2MubiFalse counts as detected
//   sw_disable_det_i      : software detection-disable request
//   selftest_start_i      : self-test start strobe
//   alarm_clear_i         : clears the sticky alarm
//   disable_corruption_detection_o, lockstep_err_injection_en_o, shadow_rst_req_o : shadow core controls
//   alarm_o, alarm_count_o, nmi_req_o : sticky alarm, saturating episode count, new-episode pulse
//   selftest_busy_o, selftest_done_o, selftest_pass_o : self-test status
module el2_lockstep_alarm_ctrl
    import el2_mubi_pkg::*;
#(
    parameter int DET_TIMEOUT       = 64,
    parameter int SHADOW_RST_CYCLES = 4,
    parameter int RECOVER_TIMEOUT   = 64,
    parameter int CNT_W             = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  el2_mubi_t        corruption_detected_i,
    input  logic             sw_disable_det_i,
    input  logic             selftest_start_i,
    input  logic             alarm_clear_i,
    output el2_mubi_t        disable_corruption_detection_o,
    output el2_mubi_t        lockstep_err_injection_en_o,
    output logic             shadow_rst_req_o,
    output logic             alarm_o,
    output logic [CNT_W-1:0] alarm_count_o,
    output logic             nmi_req_o,
    output logic             selftest_busy_o,
    output logic             selftest_done_o,
    output logic             selftest_pass_o
);
    logic det, det_q, busy, busy_nxt, rise;
    el2_mubi_t dis_q;
    logic alarm_q, nmi_q;
    logic [CNT_W-1:0] cnt_q;
    assign det = corruption_detected_i != El2MubiFalse;
    // det_q keeps tracking during self-test, so a flag still high on return to
    // IDLE is not seen as a new edge.
    assign rise = det & ~det_q & ~busy & ~sw_disable_det_i;
    el2_lockstep_selftest_fsm #(
        .DET_TIMEOUT      (DET_TIMEOUT),
        .SHADOW_RST_CYCLES(SHADOW_RST_CYCLES),
        .RECOVER_TIMEOUT  (RECOVER_TIMEOUT)
    ) u_fsm (
        .clk             (clk),
        .rst             (rst),
        .det_i           (det),
        .start_i         (selftest_start_i),
        .inj_en_o        (lockstep_err_injection_en_o),
        .shadow_rst_req_o(shadow_rst_req_o),
        .busy_o          (busy),
        .busy_nxt_o      (busy_nxt),
        .done_o          (selftest_done_o),
        .pass_o          (selftest_pass_o)
    );
    // busy_nxt keeps the registered disable aligned with the registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_q   <= 1'b0;
            dis_q   <= El2MubiFalse;
            alarm_q <= 1'b0;
            nmi_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            det_q   <= det;
            dis_q   <= (sw_disable_det_i && !busy_nxt) ? El2MubiTrue : El2MubiFalse;
            alarm_q <= rise | (alarm_q & ~alarm_clear_i);
            nmi_q   <= rise;
            cnt_q   <= (rise && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        end
    end
    assign disable_corruption_detection_o = dis_q;
    assign alarm_o                        = alarm_q;
    assign nmi_req_o                      = nmi_q;
    assign alarm_count_o                  = cnt_q;
    assign selftest_busy_o                = busy;
endmodule

// File: tb/tb_el2_lockstep_alarm_ctrl.sv
// tb_el2_lockstep_alarm_ctrl: directed self-checking bench for the lockstep alarm controller
module tb_el2_lockstep_alarm_ctrl;
    import el2_mubi_pkg::*;
    logic clk = 1'b0;
    logic rst;
    el2_mubi_t corr;
    logic sw_dis, start, clr;
    el2_mubi_t dis_o, inj_o;
    logic shrst_o, alarm_o, nmi_o, busy_o, done_o, pass_o;
    logic [7:0] cnt_o;
    int checks = 0;
    int errors = 0;
    el2_lockstep_alarm_ctrl dut (
        .clk                           (clk),
        .rst                           (rst),
        .corruption_detected_i         (corr),
        .sw_disable_det_i              (sw_dis),
        .selftest_start_i              (start),
        .alarm_clear_i                 (clr),
        .disable_corruption_detection_o(dis_o),
        .lockstep_err_injection_en_o   (inj_o),
        .shadow_rst_req_o              (shrst_o),
        .alarm_o                       (alarm_o),
        .alarm_count_o                 (cnt_o),
        .nmi_req_o                     (nmi_o),
        .selftest_busy_o               (busy_o),
        .selftest_done_o               (done_o),
        .selftest_pass_o               (pass_o)
    );
    always #5 clk = ~clk;
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        rst = 1'b1; corr = El2MubiFalse; sw_dis = 1'b0; start = 1'b0; clr = 1'b0;
        cyc(); cyc();
        checks++;
        if (dis_o !== El2MubiFalse || inj_o !== El2MubiFalse) begin
            errors++; $display("FAIL reset_mubi: dis=%h inj=%h expected %h", dis_o, inj_o, El2MubiFalse);
        end
        checks++;
        if ({shrst_o, alarm_o, nmi_o, busy_o, done_o, pass_o, cnt_o} !== 14'd0) begin
            errors++; $display("FAIL reset_outs: got %b expected 0", {shrst_o, alarm_o, nmi_o, busy_o, done_o, pass_o, cnt_o});
        end
        rst = 1'b0;
        repeat (10) cyc();
        checks++;
        if (dis_o !== El2MubiFalse || inj_o !== El2MubiFalse || {shrst_o, alarm_o, nmi_o, busy_o, done_o, pass_o, cnt_o} !== 14'd0) begin
            errors++; $display("FAIL reset_idle: dis=%h inj=%h outs=%b expected quiet", dis_o, inj_o, {shrst_o, alarm_o, nmi_o, busy_o, done_o, pass_o, cnt_o});
        end
    endtask
    task automatic test_alarm();
        int nmi = 0;
        corr = El2MubiTrue;
        repeat (5) begin cyc(); nmi += int'(nmi_o); end
        corr = El2MubiFalse;
        cyc(); nmi += int'(nmi_o);
        checks++;
        if (nmi !== 1 || alarm_o !== 1'b1 || cnt_o !== 8'd1) begin
            errors++; $display("FAIL alarm_first: nmi=%0d alarm=%b cnt=%0d expected 1/1/1", nmi, alarm_o, cnt_o);
        end
        nmi = 0;
        repeat (254) begin
            corr = El2MubiTrue; cyc(); nmi += int'(nmi_o); cyc(); nmi += int'(nmi_o);
            corr = El2MubiFalse; cyc(); nmi += int'(nmi_o);
        end
        checks++;
        if (cnt_o !== 8'd255 || nmi !== 254) begin
            errors++; $display("FAIL alarm_255: cnt=%0d nmi=%0d expected 255/254", cnt_o, nmi);
        end
        corr = El2MubiTrue; cyc(); nmi = int'(nmi_o); cyc();
        corr = El2MubiFalse; cyc();
        checks++;
        if (cnt_o !== 8'd255 || nmi !== 1) begin
            errors++; $display("FAIL alarm_sat: cnt=%0d nmi=%0d expected 255/1", cnt_o, nmi);
        end
        clr = 1'b1; cyc(); clr = 1'b0;
        checks++;
        if (alarm_o !== 1'b0 || cnt_o !== 8'd255) begin
            errors++; $display("FAIL alarm_clear: alarm=%b cnt=%0d expected 0/255", alarm_o, cnt_o);
        end
    endtask
    task automatic test_selftest_pass();
        int sh = 0, nmi = 0, cd = 0, alarm_seen = 0;
        logic prev = 1'b0, got = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        checks++;
        if (inj_o !== El2MubiTrue || busy_o !== 1'b1 || pass_o !== 1'b0) begin
            errors++; $display("FAIL pass_start: inj=%h busy=%b pass=%b expected %h/1/0", inj_o, busy_o, pass_o, El2MubiTrue);
        end
        repeat (3) cyc();
        corr = El2MubiTrue;
        for (int i = 0; i < 60 && !got; i++) begin
            cyc();
            if (cd > 0) begin cd--; if (cd == 0) corr = El2MubiFalse; end
            if (prev && !shrst_o) cd = 2;
            prev = shrst_o;
            sh += int'(shrst_o);
            nmi += int'(nmi_o);
            alarm_seen += int'(alarm_o);
            got = done_o;
        end
        checks++;
        if (got !== 1'b1 || pass_o !== 1'b1) begin
            errors++; $display("FAIL pass_result: done=%b pass=%b expected 1/1", got, pass_o);
        end
        checks++;
        if (sh !== 4) begin
            errors++; $display("FAIL pass_shrst_len: %0d cycles expected 4", sh);
        end
        cyc();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || pass_o !== 1'b1 || alarm_o !== 1'b0 || nmi !== 0 || alarm_seen !== 0) begin
            errors++; $display("FAIL pass_after: done=%b busy=%b pass=%b alarm=%b nmi=%0d expected 0/0/1/0/0", done_o, busy_o, pass_o, alarm_o, nmi);
        end
    endtask
    task automatic test_selftest_fail();
        int n = 0;
        corr = El2MubiFalse;
        start = 1'b1; cyc(); start = 1'b0;
        while (!done_o && n < 100) begin cyc(); n++; end
        checks++;
        if (n !== 65) begin
            errors++; $display("FAIL fail_latency: done after %0d cycles expected 65", n);
        end
        checks++;
        if (pass_o !== 1'b0 || inj_o !== El2MubiFalse) begin
            errors++; $display("FAIL fail_result: pass=%b inj=%h expected 0/%h", pass_o, inj_o, El2MubiFalse);
        end
        cyc();
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL fail_idle: busy=%b done=%b expected 0/0", busy_o, done_o);
        end
    endtask
    task automatic test_disable();
        int n = 0, nmi = 0;
        sw_dis = 1'b1; cyc(); cyc();
        checks++;
        if (dis_o !== El2MubiTrue) begin
            errors++; $display("FAIL dis_on: got %h expected %h", dis_o, El2MubiTrue);
        end
        corr = 4'h0;
        repeat (3) begin cyc(); nmi += int'(nmi_o); end
        corr = El2MubiFalse; cyc();
        checks++;
        if (alarm_o !== 1'b0 || nmi !== 0) begin
            errors++; $display("FAIL dis_no_alarm: alarm=%b nmi=%0d expected 0/0", alarm_o, nmi);
        end
        start = 1'b1; cyc(); start = 1'b0;
        checks++;
        if (dis_o !== El2MubiFalse || busy_o !== 1'b1) begin
            errors++; $display("FAIL dis_busy: dis=%h busy=%b expected %h/1", dis_o, busy_o, El2MubiFalse);
        end
        while (!done_o && n < 100) begin cyc(); n++; end
        cyc();
        checks++;
        if (dis_o !== El2MubiTrue || busy_o !== 1'b0) begin
            errors++; $display("FAIL dis_restore: dis=%h busy=%b expected %h/0 (waited %0d)", dis_o, busy_o, El2MubiTrue, n);
        end
        sw_dis = 1'b0; corr = 4'h3; cyc();
        nmi = int'(nmi_o);
        cyc();
        checks++;
        if (alarm_o !== 1'b1 || nmi !== 1 || dis_o !== El2MubiFalse) begin
            errors++; $display("FAIL dis_failsafe: alarm=%b nmi=%0d dis=%h expected 1/1/%h", alarm_o, nmi, dis_o, El2MubiFalse);
        end
        corr = El2MubiFalse; clr = 1'b1; cyc(); clr = 1'b0;
    endtask
    task automatic test_edge_cases();
        int n = 0;
        logic seen = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        while (!done_o && n < 100) begin
            if (n == 10) start = 1'b1;
            cyc(); n++;
            start = 1'b0;
        end
        checks++;
        if (n !== 65 || pass_o !== 1'b0) begin
            errors++; $display("FAIL edge_restart: done after %0d pass=%b expected 65/0", n, pass_o);
        end
        cyc();
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        corr = El2MubiTrue;
        for (int i = 0; i < 20 && !seen; i++) begin cyc(); seen = shrst_o; end
        checks++;
        if (seen !== 1'b1) begin
            errors++; $display("FAIL edge_shrst_seen: shadow reset not observed, expected 1");
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (shrst_o !== 1'b0 || inj_o !== El2MubiFalse || busy_o !== 1'b0) begin
            errors++; $display("FAIL edge_async_rst: shrst=%b inj=%h busy=%b expected 0/%h/0", shrst_o, inj_o, busy_o, El2MubiFalse);
        end
        corr = El2MubiFalse;
        cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if (busy_o !== 1'b0 || cnt_o !== 8'd0 || alarm_o !== 1'b0) begin
            errors++; $display("FAIL edge_post_rst: busy=%b cnt=%0d alarm=%b expected 0/0/0", busy_o, cnt_o, alarm_o);
        end
        corr = El2MubiTrue; cyc(); corr = El2MubiFalse; cyc();
        checks++;
        if (alarm_o !== 1'b1 || cnt_o !== 8'd1) begin
            errors++; $display("FAIL edge_alarm1: alarm=%b cnt=%0d expected 1/1", alarm_o, cnt_o);
        end
        corr = El2MubiTrue; clr = 1'b1; cyc(); clr = 1'b0;
        checks++;
        if (alarm_o !== 1'b1 || cnt_o !== 8'd2 || nmi_o !== 1'b1) begin
            errors++; $display("FAIL edge_clr_vs_set: alarm=%b cnt=%0d nmi=%b expected 1/2/1", alarm_o, cnt_o, nmi_o);
        end
        corr = El2MubiFalse; cyc();
        clr = 1'b1; cyc(); clr = 1'b0;
        checks++;
        if (alarm_o !== 1'b0 || cnt_o !== 8'd2) begin
            errors++; $display("FAIL edge_clear: alarm=%b cnt=%0d expected 0/2", alarm_o, cnt_o);
        end
    endtask
    initial begin
        test_reset();
        test_alarm();
        test_selftest_pass();
        test_selftest_fail();
        test_disable();
        test_edge_cases();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
